// File: rtl/red_seq_ctrl.sv
// red_seq_ctrl: multi-cycle byte-reduction sequencer sharing one SLICE_W-bit adder slice.
// Optional abort input enabled by defining RED_SEQ_FLUSH_EN.
module red_seq_ctrl #(
  parameter int SLICE_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
`ifdef RED_SEQ_FLUSH_EN
  input  logic        flush,
`endif
  output logic        busy,
  output logic        done,
  output logic [15:0] Out
);
  if (SLICE_W != 4 && SLICE_W != 2) begin : g_bad_w
    $error("red_seq_ctrl: SLICE_W must be 4 or 2");
  end
  typedef enum logic [2:0] {IDLE, UPPER, LOWER, FINAL, DONE} state_t;
  localparam logic [2:0] HALF_N = 3'(8 / SLICE_W);
  localparam logic [2:0] FULL_N = 3'(12 / SLICE_W);
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic carry_q, carry_d;
  logic [15:0] a_q, a_d, b_q, b_d, out_q, out_d;
  logic [8:0] u_q, u_d, l_q, l_d;
  logic [12:0] f_q, f_d;
  logic [11:0] xa, xb;
  logic [3:0] base;
  logic [SLICE_W-1:0] sa, sb, s;
  logic cin, cout, last, flush_w;
`ifdef RED_SEQ_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      u_q     <= '0;
      l_q     <= '0;
      f_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      u_q     <= u_d;
      l_q     <= l_d;
      f_q     <= f_d;
      out_q   <= out_d;
    end
  end
  // The final phase adds U and L sign-extended from bit 8 to 12 bits.
  always_comb begin
    xa = state_q == UPPER ? {4'h0, a_q[15:8]} : state_q == LOWER ? {4'h0, a_q[7:0]} : {{3{u_q[8]}}, u_q};
    xb = state_q == UPPER ? {4'h0, b_q[15:8]} : state_q == LOWER ? {4'h0, b_q[7:0]} : {{3{l_q[8]}}, l_q};
    base = 4'(cnt_q) * 4'(SLICE_W);
    sa = xa[base +: SLICE_W];
    sb = xb[base +: SLICE_W];
    cin = (cnt_q != 3'd0) & carry_q;
    {cout, s} = {1'b0, sa} + {1'b0, sb} + {{SLICE_W{1'b0}}, cin};
    last = cnt_q == (state_q == FINAL ? FULL_N - 3'd1 : HALF_N - 3'd1);
    state_d = state_q;
    cnt_d = cnt_q;
    carry_d = carry_q;
    a_d = a_q;
    b_d = b_q;
    u_d = u_q;
    l_d = l_q;
    f_d = f_q;
    out_d = out_q;
    if (flush_w) begin
      state_d = IDLE;
      cnt_d = '0;
      carry_d = 1'b0;
    end else if (state_q == IDLE || state_q == DONE) begin
      state_d = start ? UPPER : IDLE;
      cnt_d = '0;
      carry_d = 1'b0;
      a_d = start ? A : a_q;
      b_d = start ? B : b_q;
    end else begin
      cnt_d = last ? 3'd0 : cnt_q + 3'd1;
      carry_d = cout;
      if (state_q == UPPER) begin
        u_d[base +: SLICE_W] = s;
        u_d[8] = last ? cout : u_q[8];
      end
      if (state_q == LOWER) begin
        l_d[base +: SLICE_W] = s;
        l_d[8] = last ? cout : l_q[8];
      end
      if (state_q == FINAL) begin
        f_d[base +: SLICE_W] = s;
        f_d[12] = last ? cout : f_q[12];
        out_d = last ? {{3{f_d[12]}}, f_d} : out_q;
      end
      state_d = !last ? state_q : state_q == UPPER ? LOWER : state_q == LOWER ? FINAL : DONE;
    end
  end
  always_comb begin
    busy = state_q == UPPER || state_q == LOWER || state_q == FINAL;
    done = state_q == DONE;
    Out = out_q;
  end
endmodule
